// File: rtl/gray_counter_pkg.sv
// Shared types and helpers for the Gray-code counter slice.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package gray_pkg;

    // Widest counter any instance may use. SIZE-bit words are carried
    // zero-extended in this type and sliced back down by the caller.
    localparam int GRAY_MAX_W = 64;

    typedef logic [GRAY_MAX_W-1:0] gray_word_t;

    // Wide enough to hold a popcount of a GRAY_MAX_W-bit word.
    typedef logic [6:0] gray_dist_t;

    // Reflected binary code: each bit is the XOR of its binary bit and
    // the next more significant binary bit.
    function automatic gray_word_t bin2gray(input gray_word_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Number of bit positions in which two Gray words differ.
    function automatic gray_dist_t gray_hamming(input gray_word_t a,
                                                input gray_word_t b);
        gray_word_t diff;
        gray_dist_t cnt;
        diff = a ^ b;
        cnt  = '0;
        for (int i = 0; i < GRAY_MAX_W; i++) begin
            cnt = cnt + gray_dist_t'(diff[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/gray_counter_if.sv
// Control and output bundle of the Gray-code counter.
// Latency: none (wiring only).
// Backpressure: none; the counter accepts a control word every cycle.
// GRAY_COUNTER_CHECK_EN adds the sticky err flag to the bundle.
interface gray_counter_if #(
    parameter int SIZE = 8
);

    logic            clr;
    logic            load;
    logic [SIZE-1:0] load_val;
    logic            en;
    logic            up;
    logic [SIZE-1:0] gray;
    logic [SIZE-1:0] bin;
    logic            tc;
`ifdef GRAY_COUNTER_CHECK_EN
    logic            err;
`endif

`ifdef GRAY_COUNTER_CHECK_EN
    // Stimulus side: drives the controls, observes the count.
    modport master (
        output clr, load, load_val, en, up,
        input  gray, bin, tc, err
    );

    // Counter side.
    modport slave (
        input  clr, load, load_val, en, up,
        output gray, bin, tc, err
    );
`else
    // Stimulus side: drives the controls, observes the count.
    modport master (
        output clr, load, load_val, en, up,
        input  gray, bin, tc
    );

    // Counter side.
    modport slave (
        input  clr, load, load_val, en, up,
        output gray, bin, tc
    );
`endif

endinterface

// File: rtl/gray_counter_bin2gray_comb.sv
// Binary-to-Gray conversion, structural inverse of gray2bin_gen.
// Latency: purely combinational, 0 cycles.
// Backpressure: none.
module bin2gray_comb
    import gray_pkg::*;
#(
    parameter int SIZE = 8
) (
    input  logic [SIZE-1:0] bin,
    output logic [SIZE-1:0] gray
);

    gray_word_t bin_ext;
    gray_word_t gray_ext;

    // Widen to the package word, convert, then drop the zero upper bits.
    always_comb begin
        bin_ext  = gray_word_t'(bin);
        gray_ext = bin2gray(bin_ext);
        gray     = gray_ext[SIZE-1:0];
    end

endmodule

// File: rtl/gray_counter.sv
// Registered up/down Gray counter with clear, load and wrap/saturate limits.
// Latency: 1 cycle from control sample to gray/bin/tc.
// Backpressure: none; a new control word is taken every edge.
// GRAY_COUNTER_CHECK_EN adds a sticky single-bit-step checker on bus.err.
module gray_counter
    import gray_pkg::*;
#(
    parameter int SIZE = 8,   // counter width, must be >= 2
    parameter int WRAP = 1    // 1: modulo wrap, 0: saturate at both ends
) (
    input  logic              clk,
    input  logic              rst_n,
    gray_counter_if.slave     bus
);

    localparam logic [SIZE-1:0] MAX_VAL = '1;
    localparam logic [SIZE-1:0] MIN_VAL = '0;
    localparam logic [SIZE-1:0] ONE_VAL = SIZE'(1);

    // The binary count is the real state; gray is derived from bin_d so the
    // two registers always describe the same count on the same edge.
    logic [SIZE-1:0] bin_q;
    logic [SIZE-1:0] bin_d;
    logic [SIZE-1:0] gray_q;
    logic [SIZE-1:0] gray_d;
    logic            tc_q;
    logic            tc_d;

    // High when this edge performs an en step that actually moves the count.
    logic            step_live;
    logic            at_max;
    logic            at_min;

    assign at_max = (bin_q == MAX_VAL);
    assign at_min = (bin_q == MIN_VAL);

    // Next-state selection: clr beats load beats en; en=0 holds.
    always_comb begin
        bin_d     = bin_q;
        tc_d      = 1'b0;
        step_live = 1'b0;
        if (bus.clr) begin
            bin_d = MIN_VAL;
        end else if (bus.load) begin
            bin_d = bus.load_val;
        end else if (bus.en) begin
            if (bus.up) begin
                if (at_max) begin
                    // Limit reached: wrap to zero or stay pinned at the top.
                    tc_d = 1'b1;
                    if (WRAP != 0) begin
                        bin_d     = MIN_VAL;
                        step_live = 1'b1;
                    end
                end else begin
                    bin_d     = bin_q + ONE_VAL;
                    step_live = 1'b1;
                end
            end else begin
                if (at_min) begin
                    // Limit reached: wrap to all-ones or stay pinned at zero.
                    tc_d = 1'b1;
                    if (WRAP != 0) begin
                        bin_d     = MAX_VAL;
                        step_live = 1'b1;
                    end
                end else begin
                    bin_d     = bin_q - ONE_VAL;
                    step_live = 1'b1;
                end
            end
        end
    end

    // Gray word of the value about to be registered.
    bin2gray_comb #(
        .SIZE (SIZE)
    ) u_bin2gray (
        .bin  (bin_d),
        .gray (gray_d)
    );

    // Count, Gray and limit registers, all cleared by the async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= '0;
            gray_q <= '0;
            tc_q   <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            tc_q   <= tc_d;
        end
    end

    assign bus.bin  = bin_q;
    assign bus.gray = gray_q;
    assign bus.tc   = tc_q;

`ifdef GRAY_COUNTER_CHECK_EN
    // Remember the Gray word from before the last edge and whether that
    // edge was a live step, so the cycle after it can be judged.
    logic            step_q;
    logic [SIZE-1:0] gray_prev_q;
    logic            err_q;
    logic            err_d;
    logic            step_bad;
    gray_word_t      prev_ext;
    gray_word_t      cur_ext;
    gray_dist_t      step_dist;

    // A live step must move the Gray word by exactly one bit.
    always_comb begin
        prev_ext  = gray_word_t'(gray_prev_q);
        cur_ext   = gray_word_t'(gray_q);
        step_dist = gray_hamming(prev_ext, cur_ext);
        step_bad  = step_q && (step_dist != gray_dist_t'(1));
        err_d     = err_q | step_bad;
    end

    // Checker history and the sticky error; only reset clears err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q      <= 1'b0;
            gray_prev_q <= '0;
            err_q       <= 1'b0;
        end else begin
            step_q      <= step_live;
            gray_prev_q <= gray_q;
            err_q       <= err_d;
        end
    end

    assign bus.err = err_q;

`ifndef SYNTHESIS
    // Simulation report of the same condition the err flag captures.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!step_bad)
                else $error("gray_counter: step changed %0d gray bits", step_dist);
        end
    end
`endif
`endif

endmodule

// File: tb/tb_gray_counter.sv
// Scoreboard bench for gray_counter: one wrapping and one saturating
// instance, SIZE=5, driven with identical controls every cycle.
module tb_gray_counter;

    localparam int SIZE = 5;

    typedef struct {
        logic [SIZE-1:0] bin;
        logic [SIZE-1:0] gray;
        logic            tc;
    } exp_t;

    logic clk;
    logic rst_n;

    int vectors;
    int miscompares;

    exp_t exp_w_q[$];
    exp_t exp_s_q[$];

    logic [SIZE-1:0] cnt_w;
    logic [SIZE-1:0] cnt_s;

    gray_counter_if #(.SIZE(SIZE)) wif ();
    gray_counter_if #(.SIZE(SIZE)) sif ();

    gray_counter #(.SIZE(SIZE), .WRAP(1)) dut_w (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (wif.slave)
    );

    gray_counter #(.SIZE(SIZE), .WRAP(0)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input int unsigned obs,
                            input int unsigned exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)",
                     tag, obs, obs, exp, exp);
        end
    endtask

    function automatic logic [SIZE-1:0] to_gray(input logic [SIZE-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Reference counter behaviour for one edge.
    task automatic model_edge(input bit wrap, inout logic [SIZE-1:0] cnt,
                              output logic tc, input logic c, input logic l,
                              input logic [SIZE-1:0] lv, input logic e,
                              input logic u);
        int unsigned top;
        top = (1 << SIZE) - 1;
        tc  = 1'b0;
        if (c) cnt = '0;
        else if (l) cnt = lv;
        else if (e) begin
            if (u) begin
                if (int'(cnt) == top) begin
                    tc = 1'b1;
                    if (wrap) cnt = '0;
                end else cnt = SIZE'(int'(cnt) + 1);
            end else begin
                if (cnt == 0) begin
                    tc = 1'b1;
                    if (wrap) cnt = SIZE'(top);
                end else cnt = SIZE'(int'(cnt) - 1);
            end
        end
    endtask

    // Drive one control word, push the expectations, then compare after
    // the edge that consumes it.
    task automatic step(input logic c, input logic l, input logic [SIZE-1:0] lv,
                        input logic e, input logic u);
        exp_t ew, es, gw, gs;
        logic tcw, tcs;
        wif.clr = c; wif.load = l; wif.load_val = lv; wif.en = e; wif.up = u;
        sif.clr = c; sif.load = l; sif.load_val = lv; sif.en = e; sif.up = u;
        model_edge(1'b1, cnt_w, tcw, c, l, lv, e, u);
        model_edge(1'b0, cnt_s, tcs, c, l, lv, e, u);
        ew.bin = cnt_w; ew.gray = to_gray(cnt_w); ew.tc = tcw;
        es.bin = cnt_s; es.gray = to_gray(cnt_s); es.tc = tcs;
        exp_w_q.push_back(ew);
        exp_s_q.push_back(es);
        @(posedge clk);
        #1;
        if (exp_w_q.size() == 0 || exp_s_q.size() == 0) begin
            check_eq("scoreboard_empty", 0, 1);
        end else begin
            gw = exp_w_q.pop_front();
            gs = exp_s_q.pop_front();
            check_eq("wrap_bin",  wif.bin,  gw.bin);
            check_eq("wrap_gray", wif.gray, gw.gray);
            check_eq("wrap_tc",   wif.tc,   gw.tc);
            check_eq("sat_bin",   sif.bin,  gs.bin);
            check_eq("sat_gray",  sif.gray, gs.gray);
            check_eq("sat_tc",    sif.tc,   gs.tc);
        end
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_wrap_gray"}, wif.gray, 0);
        check_eq({tag, "_wrap_bin"},  wif.bin,  0);
        check_eq({tag, "_wrap_tc"},   wif.tc,   0);
        check_eq({tag, "_sat_gray"},  sif.gray, 0);
        check_eq({tag, "_sat_bin"},   sif.bin,  0);
        check_eq({tag, "_sat_tc"},    sif.tc,   0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cnt_w = '0;
        cnt_s = '0;
        rst_n = 1'b0;
        wif.clr = 0; wif.load = 0; wif.load_val = '0; wif.en = 0; wif.up = 0;
        sif.clr = 0; sif.load = 0; sif.load_val = '0; sif.en = 0; sif.up = 0;

        // Reset state before and across the first edge.
        #2;
        check_zero("rst_pre");
        @(posedge clk);
        #1;
        check_zero("rst_edge");
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, '0, 0, 0);

        // 32 up steps: full Gray walk and wrap on the last one.
        for (int k = 1; k <= 32; k++) begin
            step(0, 0, '0, 1, 1);
            if (k == 1)  check_eq("seq_g1",  wif.gray, 5'b00001);
            if (k == 2)  check_eq("seq_g2",  wif.gray, 5'b00011);
            if (k == 3)  check_eq("seq_g3",  wif.gray, 5'b00010);
            if (k == 31) check_eq("seq_g31", wif.gray, 5'b10000);
            if (k == 31) check_eq("seq_tc31", wif.tc, 0);
            if (k == 32) check_eq("seq_g32", wif.gray, 5'b00000);
            if (k == 32) check_eq("seq_tc32", wif.tc, 1);
        end

        // Load 19 then a single down step.
        step(0, 1, 5'd19, 0, 0);
        check_eq("ld19_gray", wif.gray, 5'b11010);
        check_eq("ld19_bin",  wif.bin,  5'b10011);
        step(0, 0, '0, 1, 0);
        check_eq("dn18_gray", wif.gray, 5'b11011);

        // Down from zero wraps, saturating copy pins; then clr beats load.
        step(1, 0, '0, 0, 0);
        step(0, 0, '0, 1, 0);
        check_eq("dnwrap_gray", wif.gray, 5'b10000);
        check_eq("dnwrap_tc",   wif.tc,   1);
        check_eq("dnsat_tc",    sif.tc,   1);
        step(0, 0, '0, 0, 0);
        check_eq("hold_tc", wif.tc, 0);
        step(1, 1, 5'd5, 1, 1);
        check_eq("clrld_bin", wif.bin, 0);

        // Saturate at the top for three cycles, then step down.
        step(0, 1, 5'd31, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, '0, 1, 1);
            check_eq("satup_gray", sif.gray, 5'b10000);
            check_eq("satup_tc",   sif.tc,   1);
        end
        step(0, 0, '0, 1, 0);
        check_eq("satdn_gray", sif.gray, 5'b10001);
        check_eq("satdn_tc",   sif.tc,   0);

        // Randomised mixed traffic.
        for (int k = 0; k < 60; k++) begin
            step(($urandom_range(15) == 0), ($urandom_range(7) == 0),
                 SIZE'($urandom), ($urandom_range(3) != 0), $urandom_range(1) == 1);
        end

        // Asynchronous reset in the middle of a cycle.
        step(0, 1, 5'b01100, 0, 0);
        check_eq("mid_bin", wif.bin, 5'b01100);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("rst_mid");
        cnt_w = '0;
        cnt_s = '0;
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, '0, 1, 1);

`ifdef GRAY_COUNTER_CHECK_EN
        check_eq("err_clean", wif.err, 0);
        // Corrupt the registered Gray word right after a live step.
        wif.en = 0; sif.en = 0;
        force dut_w.gray_q = dut_w.gray_prev_q ^ 5'b00110;
        @(posedge clk);
        #1;
        release dut_w.gray_q;
        check_eq("err_set", wif.err, 1);
        @(posedge clk);
        #1;
        check_eq("err_sticky", wif.err, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("err_rst", wif.err, 0);
        @(negedge clk);
        rst_n = 1'b1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gray_counter.md
Name: gray_counter

Overview:
- Registered Gray-code counter for the simulation examples.
- Produces the Gray word consumed by gray2bin_gen/gray2bin and a matching registered binary count, so benches can cross-check the converter against the counter's own value.
- Supports up/down counting, hold, synchronous clear, parallel load, and wrap or saturate at the limits.
- One clock domain; sits directly upstream of the Gray-to-binary stage.

Parameters:
- SIZE, 8, counter width in bits; legal range is SIZE ≥ 2.
- WRAP, 1, 1 = modulo-2^SIZE wrap-around; 0 = saturate at 0 and at 2^SIZE-1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear to zero.
- load  input  1  synchronous parallel load.
- load_val  input  SIZE  binary value for load.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement; sampled only when en=1.
- gray  output  SIZE  registered Gray code of the count.
- bin  output  SIZE  registered binary count; always equals the Gray-to-binary conversion of gray.
- tc  output  1  registered terminal-count / limit pulse.

Behaviour:
- Reset: rst_n low forces gray=0, bin=0, tc=0 immediately, independent of clk. Release is synchronous to the next rising edge; the first update follows that edge.
- Internal state is the binary count. gray = bin ^ (bin >> 1), computed from the next binary value and registered alongside it. Both outputs update on the same edge; there is no cycle of skew between them.
- Latency: any control is sampled at edge N and visible after edge N, i.e. 1 cycle.
- Priority per edge: clr > load > en > hold.
  - clr=1: count := 0; tc := 0.
  - load=1: count := load_val; tc := 0.
  - en=1, up=1: count := count+1, modulo 2^SIZE.
  - en=1, up=0: count := count-1, modulo 2^SIZE.
  - en=0: count holds; tc := 0.
- WRAP=1:
  - Up step from 2^SIZE-1 goes to 0; down step from 0 goes to 2^SIZE-1.
  - tc=1 for exactly the one cycle following a wrapping step, otherwise 0.
- WRAP=0:
  - Up step at 2^SIZE-1 and down step at 0 leave the count unchanged.
  - tc=1 in the cycle following each such blocked step. tc stays high on consecutive blocked steps.
- Every en step changes gray in exactly one bit, except blocked saturating steps, which change no bits.
- clr/load may change any number of bits.
- Arithmetic is SIZE-bit unsigned with no extension; load_val is used verbatim.
- clr and load asserted together: clr wins and load_val is ignored.
- Reset asserted mid-operation aborts the count with no recovery of prior state.

Optional Feature:
- Macro: GRAY_COUNTER_CHECK_EN.
- Defined:
  - Adds output port err (1 bit, reset 0).
  - A sticky checker sets err on the edge after a cycle in which gray changed by a Hamming distance ≠1.
  - Only cycles where the previous edge performed an unblocked en step, with no clr/load, are checked.
  - err clears only on rst_n.
  - A simulation-only immediate assertion reports the same condition via $error.
- Not defined: no err port, no checker logic, no assertion; the port list is exactly as above.

Decomposition:
- Package gray_pkg:
  - parameterised typedef pattern for SIZE-bit words;
  - function bin2gray(bin);
  - function gray_hamming(a, b) returning a popcount of a^b, used by the checker.
- Sub-module bin2gray_comb (SIZE): combinational conversion, instantiated once on the next-state binary value, before the output registers. It is the structural inverse of gray2bin_gen.
- Counter next-state logic and registers stay in gray_counter.

Test Plan:
- SIZE=5, WRAP=1; rst_n low then high, en=0 → gray=00000, bin=00000, tc=0 before and after the first edge.
- en=1, up=1 for 32 cycles → gray sequence 00000, 00001, 00011, 00010 … 10000 (count 31) then 00000. tc high only in the cycle after the 31→0 step; bin matches the gray2bin_5bit output every cycle.
- load=1, load_val=10011 (19) → next cycle bin=10011, gray=11010, tc=0. Then en=1, up=0 for one cycle → bin=10010, gray=11011.
- From count 0, en=1, up=0 → bin=11111, gray=10000, tc=1 for one cycle. Then clr=1 together with load=1, load_val=00101 → bin=00000, gray=00000.
- SIZE=5, WRAP=0; load 31 then en=1, up=1 for 3 cycles → gray stays 10000 and tc=1 for all 3 following cycles. up=0 step → gray=10001, tc=0.
- Mid-count (bin=01100) drop rst_n between edges → gray, bin and tc are 0 within the same cycle. With GRAY_COUNTER_CHECK_EN defined, a forced two-bit gray change sets err=1 and it stays 1 until rst_n.
